// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed 7-segment scanner: per-slot blanking gap, leading-zero
// suppression, per-digit blink and decimal points. All outputs are registered.
module seg_scan_ctrl #(
   parameter int SCAN_DIV     = 50000,
   parameter int BLANK_CYC    = 8,
   parameter int BLINK_FRAMES = 128
) (
   input  logic        clock,
   input  logic        rst,
   input  logic        en,
   input  logic [15:0] digits,
   input  logic [3:0]  dp_in,
   input  logic [3:0]  blink_mask,
   input  logic        lz_suppress,
   output logic [3:0]  AN,
   output logic [6:0]  SEG,
   output logic        DP,
   output logic        frame_tick
);

   localparam int CW = $clog2(SCAN_DIV);
   localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [CW-1:0] CNT_MAX   = CW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC);
   localparam logic [FW-1:0] FRAME_MAX = FW'(BLINK_FRAMES - 1);

   typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

   state_t        state_reg, state_next;
   logic [CW-1:0] cnt_reg, cnt_next;
   logic [1:0]    slot_reg, slot_next;
   logic [FW-1:0] frame_reg, frame_next;
   logic          blink_reg, blink_next;
   logic          frame_end;

   logic [3:0]    nib_reg, nib_next;
   logic          dp_lat_reg, dp_lat_next;
   logic          blank_reg, blank_next;

   logic [3:0]    an_next;
   logic [6:0]    seg_next;
   logic          dp_next;

   logic [3:0]    nib [4];
   logic [3:0]    lz_blank;

   // Digit i is a leading zero when it and every digit to its left are zero.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_digit
         assign nib[gi] = digits[4*gi +: 4];
         if (gi == 0) begin : g_lsd
            assign lz_blank[gi] = 1'b0;
         end else begin : g_upper
            assign lz_blank[gi] = lz_suppress & ~(|digits[15:4*gi]);
         end
      end
   endgenerate

   function automatic logic [6:0] hex_seg(input logic [3:0] n);
      case (n)
         4'h0: hex_seg = 7'b1000000;
         4'h1: hex_seg = 7'b1111001;
         4'h2: hex_seg = 7'b0100100;
         4'h3: hex_seg = 7'b0110000;
         4'h4: hex_seg = 7'b0011001;
         4'h5: hex_seg = 7'b0010010;
         4'h6: hex_seg = 7'b0000010;
         4'h7: hex_seg = 7'b1111000;
         4'h8: hex_seg = 7'b0000000;
         4'h9: hex_seg = 7'b0010000;
         4'hA: hex_seg = 7'b0001000;
         4'hB: hex_seg = 7'b0000011;
         4'hC: hex_seg = 7'b1000110;
         4'hD: hex_seg = 7'b0100001;
         4'hE: hex_seg = 7'b0000110;
         default: hex_seg = 7'b0001110;
      endcase
   endfunction

   // Scan position and FSM: the state tracks which part of the slot cnt is in.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      slot_next  = slot_reg;
      frame_end  = 1'b0;
      if (!en) begin
         state_next = IDLE;
         cnt_next   = '0;
         slot_next  = '0;
      end else if (state_reg == IDLE) begin
         state_next = BLANK;
         cnt_next   = '0;
         slot_next  = '0;
      end else begin
         if (cnt_reg == CNT_MAX) begin
            cnt_next  = '0;
            slot_next = slot_reg + 2'd1;
            frame_end = (slot_reg == 2'd3);
         end else begin
            cnt_next = cnt_reg + 1'b1;
         end
         state_next = (cnt_next < BLANK_END) ? BLANK : DRIVE;
      end
   end

   always_comb begin
      frame_next = frame_reg;
      blink_next = blink_reg;
      if (frame_end) begin
         if (frame_reg == FRAME_MAX) begin
            frame_next = '0;
            blink_next = ~blink_reg;
         end else begin
            frame_next = frame_reg + 1'b1;
         end
      end
   end

   // Slot contents are captured once at cnt==0 so mid-slot input changes wait.
   always_comb begin
      nib_next    = nib_reg;
      dp_lat_next = dp_lat_reg;
      blank_next  = blank_reg;
      if (state_reg != IDLE && cnt_reg == '0) begin
         nib_next    = nib[slot_reg];
         dp_lat_next = dp_in[slot_reg];
         blank_next  = lz_blank[slot_reg] | (blink_mask[slot_reg] & blink_reg);
      end
   end

   always_comb begin
      an_next  = 4'hF;
      seg_next = 7'h7F;
      dp_next  = 1'b1;
      if (state_reg == DRIVE && !blank_reg) begin
         an_next  = ~(4'b0001 << slot_reg);
         seg_next = hex_seg(nib_reg);
         dp_next  = ~dp_lat_reg;
      end
   end

   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         state_reg  <= IDLE;
         cnt_reg    <= '0;
         slot_reg   <= '0;
         frame_reg  <= '0;
         blink_reg  <= 1'b0;
         nib_reg    <= '0;
         dp_lat_reg <= 1'b0;
         blank_reg  <= 1'b1;
         AN         <= 4'hF;
         SEG        <= 7'h7F;
         DP         <= 1'b1;
         frame_tick <= 1'b0;
      end else begin
         state_reg  <= state_next;
         cnt_reg    <= cnt_next;
         slot_reg   <= slot_next;
         frame_reg  <= frame_next;
         blink_reg  <= blink_next;
         nib_reg    <= nib_next;
         dp_lat_reg <= dp_lat_next;
         blank_reg  <= blank_next;
         AN         <= an_next;
         SEG        <= seg_next;
         DP         <= dp_next;
         frame_tick <= frame_end;
      end
   end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: absolute-time scan model checked every cycle, plus
// directed scenarios with hand-computed values.
module tb_seg_scan_ctrl;

   localparam int SD = 4;
   localparam int BC = 1;
   localparam int BF = 2;

   logic        clock = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0;
   logic [15:0] digits = 16'h0000;
   logic [3:0]  dp_in = 4'h0;
   logic [3:0]  blink_mask = 4'h0;
   logic        lz_suppress = 1'b0;
   logic [3:0]  AN;
   logic [6:0]  SEG;
   logic        DP;
   logic        frame_tick;

   int n_chk = 0;
   int n_fail = 0;
   bit chk_on = 1'b0;

   seg_scan_ctrl #(.SCAN_DIV(SD), .BLANK_CYC(BC), .BLINK_FRAMES(BF)) dut (
      .clock(clock), .rst(rst), .en(en), .digits(digits), .dp_in(dp_in),
      .blink_mask(blink_mask), .lz_suppress(lz_suppress),
      .AN(AN), .SEG(SEG), .DP(DP), .frame_tick(frame_tick)
   );

   always #5 clock = ~clock;

   logic [6:0] seg_tab [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

   // Model: pos counts cycles since the scan started; slot/phase follow by division.
   bit         active = 1'b0;
   int         pos = 0;
   int         frames = 0;
   int         mc, ms;
   logic [3:0] cur_nib = 4'h0;
   logic       cur_dp = 1'b0;
   logic       cur_blank = 1'b1;
   logic [3:0] exp_an = 4'hF;
   logic [6:0] exp_seg = 7'h7F;
   logic       exp_dp = 1'b1;
   logic       exp_ft = 1'b0;

   always @(posedge clock or posedge rst) begin
      if (rst) begin
         active = 1'b0; pos = 0; frames = 0;
         exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1; exp_ft = 1'b0;
      end else begin
         exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1; exp_ft = 1'b0;
         if (active) begin
            mc = pos % SD;
            ms = (pos / SD) % 4;
            if (mc == 0) begin
               cur_nib   = digits[ms*4 +: 4];
               cur_dp    = dp_in[ms];
               cur_blank = (lz_suppress && ms > 0 && (digits >> (4*ms)) == 16'd0) ||
                           (blink_mask[ms] && ((frames / BF) % 2 == 1));
            end
            if (mc >= BC && !cur_blank) begin
               exp_an  = ~(4'b0001 << ms);
               exp_seg = seg_tab[cur_nib];
               exp_dp  = ~cur_dp;
            end
            if (en) begin
               if (mc == SD-1 && ms == 3) begin
                  exp_ft = 1'b1;
                  frames++;
               end
               pos++;
            end else begin
               active = 1'b0;
            end
         end else if (en) begin
            active = 1'b1;
            pos = 0;
         end
      end
   end

   always @(negedge clock) begin
      if (chk_on && !rst) begin
         n_chk++;
         if (AN !== exp_an || SEG !== exp_seg || DP !== exp_dp || frame_tick !== exp_ft) begin
            n_fail++;
            $display("FAIL model t=%0t: got AN=%b SEG=%b DP=%b ft=%b, expected AN=%b SEG=%b DP=%b ft=%b",
                     $time, AN, SEG, DP, frame_tick, exp_an, exp_seg, exp_dp, exp_ft);
         end
      end
   end

   task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic wait_neg(input int n);
      repeat (n) @(negedge clock);
   endtask

   int  cnt0, cnt1, bad, segbad;
   bit  found;

   initial begin
      wait_neg(3);
      check("reset AN", 16'(AN), 16'h000F);
      check("reset SEG", 16'(SEG), 16'h007F);
      check("reset DP/tick", 16'({DP, frame_tick}), 16'h0002);
      rst = 1'b0;
      chk_on = 1'b1;
      wait_neg(1);
      check("idle AN", 16'(AN), 16'h000F);

      // Plain scan of 1234
      digits = 16'h1234; en = 1'b1;
      wait_neg(3);
      check("slot0 lit", 16'({AN, SEG}), 16'({4'b1110, 7'b0011001}));
      wait_neg(4);
      check("slot1 lit", 16'({AN, SEG}), 16'({4'b1101, 7'b0110000}));
      wait_neg(4);
      check("slot2 lit", 16'({AN, SEG}), 16'({4'b1011, 7'b0100100}));
      wait_neg(4);
      check("slot3 lit", 16'({AN, SEG}), 16'({4'b0111, 7'b1111001}));
      wait_neg(2);
      check("frame_tick high", 16'(frame_tick), 16'h0001);
      wait_neg(1);
      check("frame_tick low", 16'(frame_tick), 16'h0000);

      // Drop enable during slot 2 DRIVE
      wait_neg(9);
      check("slot2 before en drop", 16'(AN), 16'(4'b1011));
      en = 1'b0;
      wait_neg(2);
      check("dark after en drop", 16'(AN), 16'h000F);
      wait_neg(3);
      en = 1'b1;
      wait_neg(1);
      check("restart blank", 16'(AN), 16'h000F);
      wait_neg(2);
      check("restart slot0", 16'({AN, SEG}), 16'({4'b1110, 7'b0011001}));

      // Digits and dp change in the middle of slot 1
      wait_neg(3);
      digits = 16'h5678; dp_in = 4'b0100;
      wait_neg(1);
      check("slot1 keeps old", 16'({AN, SEG, DP}), 16'({4'b1101, 7'b0110000, 1'b1}));
      wait_neg(4);
      check("slot2 new + dp", 16'({AN, SEG, DP}), 16'({4'b1011, 7'b0000010, 1'b0}));
      wait_neg(4);
      check("slot3 new", 16'({AN, SEG, DP}), 16'({4'b0111, 7'b0010010, 1'b1}));
      wait_neg(4);
      check("slot0 new", 16'({AN, SEG, DP}), 16'({4'b1110, 7'b0000000, 1'b1}));

      // Leading-zero suppression on 0012
      digits = 16'h0012; dp_in = 4'h0; lz_suppress = 1'b1;
      wait_neg(20);
      cnt0 = 0; cnt1 = 0; bad = 0; segbad = 0;
      for (int i = 0; i < 32; i++) begin
         @(negedge clock);
         if (AN == 4'b0111 || AN == 4'b1011) bad++;
         if (AN == 4'b1101) begin cnt1++; if (SEG !== 7'b1111001) segbad++; end
         if (AN == 4'b1110) begin cnt0++; if (SEG !== 7'b0100100) segbad++; end
      end
      check("lz suppressed lit", 16'(bad), 16'd0);
      check("lz digit1 cycles", 16'(cnt1), 16'd6);
      check("lz digit0 cycles", 16'(cnt0), 16'd6);
      check("lz seg values", 16'(segbad), 16'd0);

      // Blink digit 0: lit 2 frames of every 4
      blink_mask = 4'b0001;
      wait_neg(20);
      cnt0 = 0; cnt1 = 0; segbad = 0;
      for (int i = 0; i < 64; i++) begin
         @(negedge clock);
         if (AN == 4'b1101) cnt1++;
         if (AN == 4'b1110) begin cnt0++; if (SEG !== 7'b0100100) segbad++; end
      end
      check("blink digit0 cycles", 16'(cnt0), 16'd6);
      check("blink digit1 cycles", 16'(cnt1), 16'd12);
      check("blink seg values", 16'(segbad), 16'd0);

      // Asynchronous reset while a digit is lit
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clock);
         if (AN != 4'hF) found = 1'b1;
      end
      check("lit before reset", 16'(found), 16'h0001);
      #2 rst = 1'b1;
      #1;
      check("async rst AN", 16'(AN), 16'h000F);
      check("async rst SEG", 16'(SEG), 16'h007F);
      check("async rst DP/tick", 16'({DP, frame_tick}), 16'h0002);
      @(negedge clock);
      rst = 1'b0;
      wait_neg(3);
      check("post-reset slot0", 16'({AN, SEG}), 16'({4'b1110, 7'b0100100}));
      wait_neg(8);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000: clock cycles per digit slot, legal range 2 or more.
REQ-002 SHALL have parameter BLANK_CYC, default 8: all-anodes-off cycles at the start of each slot, legal range 1 to SCAN_DIV-1.
REQ-003 SHALL have parameter BLINK_FRAMES, default 128: full 4-digit frames per blink half-period, legal range 1 or more.
REQ-004 SHALL use one clock; reset is asynchronous and active-high; ports are named clock and rst.
REQ-005 SHALL provide port: clock  in  1  system clock, rising edge.
REQ-006 SHALL provide port: rst  in  1  async active-high reset.
REQ-007 SHALL provide port: en  in  1  scan enable.
REQ-008 SHALL provide port: digits  in  16  four hex nibbles; digit0 is [3:0] (rightmost), digit3 is [15:12].
REQ-009 SHALL provide port: dp_in  in  4  decimal point request per digit, 1 = on.
REQ-010 SHALL provide port: blink_mask  in  4  1 = digit blinks.
REQ-011 SHALL provide port: lz_suppress  in  1  leading-zero suppression enable.
REQ-012 SHALL provide port: AN  out  4  anode enables, active-low, AN[i] = digit i.
REQ-013 SHALL provide port: SEG  out  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-014 SHALL provide port: DP  out  1  decimal point, active-low.
REQ-015 SHALL provide port: frame_tick  out  1  one-cycle pulse per completed frame.

Function
REQ-016 SHALL implement a prescaler cnt (0..SCAN_DIV-1) and a slot counter (0..3); on cnt==SCAN_DIV-1, cnt wraps to 0 and slot advances by 1, wrapping 3->0.
REQ-017 SHALL implement an FSM with states IDLE, BLANK and DRIVE: IDLE when en=0; BLANK when cnt<BLANK_CYC; DRIVE otherwise.
REQ-018 SHALL, in IDLE, hold cnt=0, slot=0, blink state frozen, and all outputs off; on en=1, start at slot 0 in BLANK.
REQ-019 SHALL latch the active digit nibble, dp bit, and blank decision at cnt==0 of each slot; input changes mid-slot take effect at the next slot.
REQ-020 SHALL make all outputs registered, with 1-cycle latency from the cnt/slot/state value that produced them.
REQ-021 SHALL drive, in BLANK: AN=4'b1111, SEG=7'h7F, DP=1.
REQ-022 SHALL drive, in DRIVE: AN = 1110/1101/1011/0111 for slot 0/1/2/3, SEG = hex decode of the latched nibble, and DP = ~dp bit.
REQ-023 SHALL use this active-low hex decode: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-024 SHALL blank digit i (i=1..3) when lz_suppress=1 and nibbles i..3 are all zero; digit0 is never suppressed.
REQ-025 SHALL blank digit i when blink_mask[i]=1 and blink_phase=1.
REQ-026 SHALL treat a blanked digit's slot exactly as BLANK (AN=1111, SEG=7F, DP=1) for the whole slot, with timing unchanged.
REQ-027 SHALL pulse frame_tick for one cycle when slot wraps 3->0.
REQ-028 SHALL count frames in a frame counter; at BLINK_FRAMES-1 it wraps to 0 and blink_phase toggles.
REQ-029 SHALL, when en falls mid-slot, enter IDLE on the next edge, with outputs off one cycle later; no partial frame_tick is issued.

Reset
REQ-030 SHALL, on rst=1, immediately (asynchronously) set AN=4'hF, SEG=7'h7F, DP=1, frame_tick=0, cnt=0, slot=0, frame count=0, blink_phase=0, state=IDLE.
REQ-031 SHALL, after rst release with en=1, enter BLANK of slot 0 on the first edge.

Verification (SCAN_DIV=4, BLANK_CYC=1, BLINK_FRAMES=2)
REQ-032 SHALL verify: assert rst mid-DRIVE -> AN=1111, SEG=1111111, DP=1, frame_tick=0 without waiting for a clock edge.
REQ-033 SHALL verify: digits=16'h1234, en=1, masks 0 -> each 4-cycle slot shows 1 cycle AN=1111, then 3 cycles AN=1110 SEG=0011001, then AN=1101 SEG=0110000, and so on; frame_tick every 16 cycles.
REQ-034 SHALL verify: digits=16'h0012, lz_suppress=1 -> AN never 0111 or 1011; digit1 shows 1111001 and digit0 shows 0100100.
REQ-035 SHALL verify: blink_mask=0001 -> digit0 lit in frames 0-1, dark in frames 2-3, period 64 cycles; other digits unaffected.
REQ-036 SHALL verify: en=0 during slot 2 DRIVE -> AN=1111 within 2 cycles; en=1 again -> first lit slot is slot 0 after 1 BLANK cycle.
REQ-037 SHALL verify: dp_in=0100 and digits change mid-slot -> DP=0 only in slot 2; the new nibble appears only from the next slot start.
